adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
- Sequences the adc sampling probe: decides which clock edges produce a logged (time, value) sample.
- Supports a programmable start time, an optional rising-level trigger, decimation and a bounded sample count.
- Sits between the emulated datapath (signal and time_curr) and the adc logger; drives its sample strobe and the registered time/value pair.

Parameters:
- SIG_BITS, 16, width of the signed sampled signal.
- DECIM_BITS, 8, width of the decimation ratio.
- CNT_BITS, 16, width of the sample count and index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- time_curr  in  TIME_FORMAT  current emulated time, unsigned fixed point with TIME_POINT fractional bits.
- time_vld  in  1  time_curr is defined; sampling and time compare are gated by it.
- sig  in  SIG_BITS  signed signal to be sampled.
- arm  in  1  pulse that latches the cfg_* inputs and starts a capture.
- abort  in  1  pulse that returns the block to IDLE.
- cfg_t_start  in  TIME_FORMAT  earliest time at which capture may begin.
- cfg_trig_en  in  1  wait for a rising crossing of cfg_trig_level before capturing.
- cfg_trig_level  in  SIG_BITS  signed trigger threshold.
- cfg_decim  in  DECIM_BITS  take one sample every cfg_decim+1 valid cycles.
- cfg_n_samp  in  CNT_BITS  number of samples to take; 0 = unbounded.
- samp_en  out  1  one-cycle strobe: samp_time/samp_val/samp_idx are valid.
- samp_time  out  TIME_FORMAT  time_curr at the sampled edge.
- samp_val  out  SIG_BITS  sig at the sampled edge.
- samp_idx  out  CNT_BITS  0-based index of this sample.
- busy  out  1  high in WAIT_T, WAIT_TRIG and CAPTURE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output and internal register is 0.
- State IDLE:
  - arm latches all cfg_* into shadow registers; next state is WAIT_T.
- State WAIT_T:
  - When time_vld and time_curr >= t_start (unsigned compare), go to WAIT_TRIG if trig_en, else CAPTURE.
- State WAIT_TRIG:
  - The first cycle with time_vld only loads the previous-value register; no crossing can be detected that cycle.
  - A crossing is prev < level and sig >= level (signed compare), with time_vld.
  - On a crossing, go to CAPTURE. The crossing cycle itself is not sampled.
- State CAPTURE:
  - Decimation counter dc is 0 on entry.
  - On each time_vld cycle: if dc==0, take a sample; then dc <= (dc==decim) ? 0 : dc+1.
  - When time_vld=0, dc holds and no sample is taken.
  - Sample latency is 1 cycle: samp_en=1 with samp_time/samp_val equal to the time_curr/sig present at the sampling edge; samp_idx=cnt; cnt increments.
  - If n_samp != 0 and cnt+1 == n_samp at the sampling edge, go to DONE.
  - If n_samp == 0, capture continues until abort; cnt saturates at all-ones.
- State DONE:
  - done=1; busy=0.
  - arm re-latches cfg_*, clears done and cnt, and goes to WAIT_T.
- arm is ignored in WAIT_T, WAIT_TRIG and CAPTURE.
- abort in any state: next state IDLE and done=0. abort beats arm and beats a sample on the same edge (samp_en=0).
- samp_en is 0 on every cycle without a sample. samp_time, samp_val and samp_idx hold their last values.
- decim=0 samples every valid cycle.
- time_curr wrap-around is not handled; TIME_FORMAT is sized so wrap does not occur within a run.
- Config changes while busy have no effect; only shadow copies are used.

Decomposition:
- New package adc_ctrl_package holds:
  - capture state enum typedef (IDLE, WAIT_T, WAIT_TRIG, CAPTURE, DONE);
  - default widths for the parameters.
- TIME_FORMAT and TIME_POINT come from time_package.
- One sub-module, adc_trig_detect:
  - holds the previous-value register and the signed crossing compare;
  - has a clear input driven on WAIT_TRIG entry;
  - outputs a crossing flag.
- Counters and the FSM live in the top module.

Test Plan:
- arm with t_start=100, trig_en=0, decim=0, n_samp=4; time_curr ramps 0,1,2…; sample at every time_vld cycle -> first samp_en at the cycle after time_curr=100 is sampled.
  - Expect samp_time=101,102,103,104 and samp_idx=0..3, since the WAIT_T to CAPTURE transition costs one cycle.
  - Then done=1, busy=0.
- decim=2, n_samp=3, t_start=0 -> samples on every 3rd valid cycle, samp_idx 0,1,2, then DONE.
  - Deassert time_vld for 2 cycles mid-run -> spacing stretches by exactly 2 cycles.
- trig_en=1, level=0, sig sequence -5,-1,0,3 -> the crossing is detected at sig=0.
  - First captured sample is sig=3; a sig that starts at 0 does not trigger until it falls below 0 and rises again.
- abort asserted on the same edge as a scheduled sample in CAPTURE -> samp_en stays 0, state IDLE, done=0.
  - Subsequent arm restarts with samp_idx=0.
- rst_n pulsed low mid-CAPTURE, asynchronously between edges -> all outputs 0 immediately; arm then works normally.
  - n_samp=0 run -> samples continue indefinitely until abort.

Source files
------------

// File: rtl/adc_ctrl_package.sv
// Shared types and default widths for the adc capture sequencer.
package adc_ctrl_package;
  localparam int DEF_SIG_BITS   = 16;
  localparam int DEF_DECIM_BITS = 8;
  localparam int DEF_CNT_BITS   = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_T    = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } capture_state_t;
endpackage

// File: rtl/time_package.sv
// Emulated-time number format shared by the datapath and its probes.
package time_package;
  localparam int TIME_FORMAT = 32;
  localparam int TIME_POINT  = 8;
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Bundle between the emulated datapath / host config and the adc logger.
interface adc_capture_ctrl_if
  import time_package::*;
  import adc_ctrl_package::*;
#(
  parameter int SIG_BITS   = DEF_SIG_BITS,
  parameter int DECIM_BITS = DEF_DECIM_BITS,
  parameter int CNT_BITS   = DEF_CNT_BITS
);
  logic [TIME_FORMAT-1:0]      time_curr;
  logic                        time_vld;
  logic signed [SIG_BITS-1:0]  sig;
  logic                        arm;
  logic                        abort;
  logic [TIME_FORMAT-1:0]      cfg_t_start;
  logic                        cfg_trig_en;
  logic signed [SIG_BITS-1:0]  cfg_trig_level;
  logic [DECIM_BITS-1:0]       cfg_decim;
  logic [CNT_BITS-1:0]         cfg_n_samp;
  // samp_en is a one-cycle valid strobe with no ready: the logger must take
  // every strobe; samp_time/samp_val/samp_idx hold their value between strobes.
  logic                        samp_en;
  logic [TIME_FORMAT-1:0]      samp_time;
  logic signed [SIG_BITS-1:0]  samp_val;
  logic [CNT_BITS-1:0]         samp_idx;
  logic                        busy;
  logic                        done;

  modport master (
    output time_curr, time_vld, sig, arm, abort,
           cfg_t_start, cfg_trig_en, cfg_trig_level, cfg_decim, cfg_n_samp,
    input  samp_en, samp_time, samp_val, samp_idx, busy, done
  );

  modport slave (
    input  time_curr, time_vld, sig, arm, abort,
           cfg_t_start, cfg_trig_en, cfg_trig_level, cfg_decim, cfg_n_samp,
    output samp_en, samp_time, samp_val, samp_idx, busy, done
  );
endinterface

// File: rtl/adc_trig_detect.sv
// Rising-level crossing detector; the first valid cycle after clear only primes prev.
module adc_trig_detect #(
  parameter int SIG_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       vld,
  input  logic signed [SIG_BITS-1:0] sig,
  input  logic signed [SIG_BITS-1:0] level,
  output logic                       crossing
);
  logic signed [SIG_BITS-1:0] prev;
  logic                       prev_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (clear) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (en && vld) begin
      prev     <= sig;
      prev_vld <= 1'b1;
    end
  end

  assign crossing = en && vld && prev_vld && (prev < level) && (sig >= level);
endmodule

// File: rtl/adc_capture_ctrl.sv
// Decides which clock edges produce a logged (time, value) sample for the adc probe.
module adc_capture_ctrl
  import time_package::*;
  import adc_ctrl_package::*;
#(
  parameter int SIG_BITS   = DEF_SIG_BITS,
  parameter int DECIM_BITS = DEF_DECIM_BITS,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  adc_capture_ctrl_if.slave  bus,
  output capture_state_t     dbg_state
);
  capture_state_t state, state_nxt;

  logic [TIME_FORMAT-1:0]     t_start_q;
  logic                       trig_en_q;
  logic signed [SIG_BITS-1:0] level_q;
  logic [DECIM_BITS-1:0]      decim_q;
  logic [CNT_BITS-1:0]        n_samp_q;

  logic [DECIM_BITS-1:0]      dc;
  logic [CNT_BITS-1:0]        cnt;

  logic                       samp_en_q;
  logic [TIME_FORMAT-1:0]     samp_time_q;
  logic signed [SIG_BITS-1:0] samp_val_q;
  logic [CNT_BITS-1:0]        samp_idx_q;

  logic arm_ok, time_ok, take, last, crossing, trig_clear;

  // abort wins over arm and over a scheduled sample on the same edge
  assign arm_ok     = bus.arm && !bus.abort && (state == IDLE || state == DONE);
  assign time_ok    = bus.time_vld && (bus.time_curr >= t_start_q);
  assign take       = (state == CAPTURE) && bus.time_vld && (dc == '0) && !bus.abort;
  assign last       = take && (n_samp_q != '0) && ((cnt + CNT_BITS'(1)) == n_samp_q);
  assign trig_clear = (state == WAIT_T) && (state_nxt == WAIT_TRIG);

  adc_trig_detect #(.SIG_BITS(SIG_BITS)) u_trig (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (trig_clear),
    .en       (state == WAIT_TRIG),
    .vld      (bus.time_vld),
    .sig      (bus.sig),
    .level    (level_q),
    .crossing (crossing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (bus.arm) state_nxt = WAIT_T;
        WAIT_T:    if (time_ok) state_nxt = trig_en_q ? WAIT_TRIG : CAPTURE;
        WAIT_TRIG: if (crossing) state_nxt = CAPTURE;
        CAPTURE:   if (last) state_nxt = DONE;
        DONE:      if (bus.arm) state_nxt = WAIT_T;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_start_q <= '0;
      trig_en_q <= 1'b0;
      level_q   <= '0;
      decim_q   <= '0;
      n_samp_q  <= '0;
    end else if (arm_ok) begin
      t_start_q <= bus.cfg_t_start;
      trig_en_q <= bus.cfg_trig_en;
      level_q   <= bus.cfg_trig_level;
      decim_q   <= bus.cfg_decim;
      n_samp_q  <= bus.cfg_n_samp;
    end
  end

  // dc restarts at 0 whenever CAPTURE is (re)entered; it only advances on valid time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc  <= '0;
      cnt <= '0;
    end else begin
      if (state != CAPTURE)  dc <= '0;
      else if (bus.time_vld) dc <= (dc == decim_q) ? '0 : dc + DECIM_BITS'(1);

      if (arm_ok)                  cnt <= '0;
      else if (take && cnt != '1)  cnt <= cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_en_q   <= 1'b0;
      samp_time_q <= '0;
      samp_val_q  <= '0;
      samp_idx_q  <= '0;
    end else begin
      samp_en_q <= take;
      if (take) begin
        samp_time_q <= bus.time_curr;
        samp_val_q  <= bus.sig;
        samp_idx_q  <= cnt;
      end
    end
  end

  assign bus.samp_en   = samp_en_q;
  assign bus.samp_time = samp_time_q;
  assign bus.samp_val  = samp_val_q;
  assign bus.samp_idx  = samp_idx_q;
  assign bus.busy      = (state == WAIT_T) || (state == WAIT_TRIG) || (state == CAPTURE);
  assign bus.done      = (state == DONE);
  assign dbg_state     = state;
endmodule
